// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared width and FSM state encoding for the divider scheduler
package div_sched_pkg;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} sched_state_t;
endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: requester-side request/response bus of the divider scheduler
interface div_sched_if import div_sched_pkg::*; #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][DATA_W-1:0] req_dividend;
    logic [N_REQ-1:0][DATA_W-1:0] req_divisor;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]            rsp_quotient;
    logic [DATA_W-1:0]            rsp_remainder;
    logic                         rsp_dbz;
    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz
    );
    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz
    );
endinterface

// File: rtl/div_sched_arb.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);
    logic [N-1:0] rot;
    logic [N-1:0] low;
    // rotate so ptr sits at bit 0, keep the lowest set bit, rotate back
    assign rot = N'({req, req} >> ptr);
    assign low = rot & (~rot + N'(1));
    assign gnt = N'(({low, low} << ptr) >> N);
    assign any = |req;
    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N; i++) gnt_id = gnt[i] ? ID_W'(i) : gnt_id;
    end
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin sharing of one start/done divider among N_REQ requesters
module div_sched import div_sched_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    div_sched_if.slave        bus,
    output logic              busy,
    output logic              div_start,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder,
    input  logic              div_done
);
    sched_state_t      state, nxt;
    logic [ID_W-1:0]   ptr, gid, gnt_id;
    logic [N_REQ-1:0]  gnt;
    logic              any, accept, dbz_req, dbz_r;
    logic [DATA_W-1:0] sel_a, sel_b, q_r, r_r;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign sel_a             = bus.req_dividend[gnt_id];
    assign sel_b             = bus.req_divisor[gnt_id];
    assign dbz_req           = sel_b == '0;
    assign accept            = state == IDLE && any;
    assign bus.req_ready     = state == IDLE ? gnt : '0;
    assign bus.rsp_valid     = state == RESP ? N_REQ'(1) << gid : '0;
    assign bus.rsp_quotient  = q_r;
    assign bus.rsp_remainder = r_r;
    assign bus.rsp_dbz       = dbz_r;
    assign busy              = state != IDLE;
    assign div_start         = state == ISSUE;

    // done is only trusted in BUSY; a level left over from the last op is ignored
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = !any ? IDLE : dbz_req ? RESP : ISSUE;
            ISSUE:   nxt = BUSY;
            BUSY:    nxt = div_done ? RESP : BUSY;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gid          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            q_r          <= '0;
            r_r          <= '0;
            dbz_r        <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                gid <= gnt_id;
                ptr <= gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
                // zero divisors are answered here and never reach the divider operands
                if (dbz_req) begin
                    q_r   <= '0;
                    r_r   <= sel_a;
                    dbz_r <= 1'b1;
                end else begin
                    div_dividend <= sel_a;
                    div_divisor  <= sel_b;
                end
            end
            if (state == BUSY && div_done) begin
                q_r   <= div_quotient;
                r_r   <= div_remainder;
                dbz_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: random and directed requests against a cycle-level model of the scheduler
module tb_div_sched;
    import div_sched_pkg::*;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, div_start, div_done;
    logic [15:0] div_dividend, div_divisor, div_quotient, div_remainder;

    div_sched_if #(.N_REQ(N)) bus ();

    div_sched #(.N_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done)
    );

    always #5 clk = ~clk;

    // divider stand-in: random latency, done level held until the next start
    logic [15:0] da, db;
    int          dcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_done      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            dcnt          <= 0;
        end else if (div_start) begin
            div_done <= 1'b0;
            da       <= div_dividend;
            db       <= div_divisor;
            dcnt     <= $urandom_range(1, 6);
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && db != 0) begin
                div_done      <= 1'b1;
                div_quotient  <= da / db;
                div_remainder <= da % db;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: one outstanding operation, timed in cycles since its accept
    bit          pend = 0, m_dbz = 0, seen = 0, exp_rsp = 0;
    int          g, k = 0, m_id = 0, m_ptr = 0, base = 0;
    logic [N-1:0]  exp_ready, exp_rv, acc = '0;
    logic [15:0] m_a = 0, m_b = 0, last_a = 0, last_b = 0;
    int          glog[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_start", div_start, 0);
            chk("rst_results", {bus.rsp_quotient, bus.rsp_remainder}, 0);
            chk("rst_dbz", bus.rsp_dbz, 0);
            chk("rst_operands", {div_dividend, div_divisor}, 0);
            pend = 0; m_ptr = 0; last_a = 0; last_b = 0; acc = '0; seen = 0;
        end else begin
            g = -1;
            if (!pend)
                for (int j = 0; j < N; j++)
                    if (g < 0 && bus.req_valid[(m_ptr + j) % N]) g = (m_ptr + j) % N;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_rsp = pend && (m_dbz ? k == 1 : seen);
            exp_rv = '0;
            if (exp_rsp) exp_rv[m_id] = 1'b1;
            chk("req_ready", bus.req_ready, exp_ready);
            chk("div_start", div_start, pend && !m_dbz && k == 1);
            chk("busy", busy, pend);
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            chk("div_operands", {div_dividend, div_divisor}, {last_a, last_b});
            if (exp_rsp) begin
                chk("rsp_quotient", bus.rsp_quotient, m_dbz ? 16'd0 : m_a / m_b);
                chk("rsp_remainder", bus.rsp_remainder, m_dbz ? m_a : m_a % m_b);
                chk("rsp_dbz", bus.rsp_dbz, m_dbz);
            end
            acc = bus.req_ready;
            if (pend) begin
                if (exp_rsp) pend = 0;
                else begin
                    if (!m_dbz && k >= 2 && div_done) seen = 1;
                    k++;
                end
            end else if (g >= 0) begin
                pend = 1; k = 1; seen = 0; m_id = g;
                m_a = bus.req_dividend[g];
                m_b = bus.req_divisor[g];
                m_dbz = m_b == 0;
                m_ptr = (g + 1) % N;
                glog.push_back(g);
                if (!m_dbz) begin
                    last_a = m_a;
                    last_b = m_b;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[i]    = 1'b1;
        bus.req_dividend[i] = a;
        bus.req_divisor[i]  = b;
    endtask

    task automatic drive(input bit rnd);
        for (int i = 0; i < N; i++)
            if (acc[i] || !bus.req_valid[i]) begin
                if (!rnd || $urandom_range(3) == 0)
                    set_req(i, 16'($urandom), $urandom_range(5) == 0 ? 16'd0 :
                            $urandom_range(1) == 1 ? 16'($urandom_range(1, 20)) : 16'($urandom_range(1, 65535)));
                else bus.req_valid[i] = 1'b0;
            end else if (rnd && $urandom_range(19) == 0) bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            step();
            for (int i = 0; i < N; i++) if (acc[i]) bus.req_valid[i] = 1'b0;
            if (bus.req_valid == '0 && !busy) break;
        end
        chk("drain_idle", busy, 0);
    endtask

    task automatic wait_rsp();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) break;
        end
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        repeat (3) step();
        chk("por_state", dut.state, IDLE);
        rst_n = 1'b1;
        step();
        // requester 1, 100/7
        set_req(1, 100, 7);
        @(negedge clk); chk("t1_ready", bus.req_ready, 4'b0010);
        step(); bus.req_valid[1] = 1'b0;
        @(negedge clk); chk("t1_start", div_start, 1); chk("t1_dividend", div_dividend, 100);
        wait_rsp();
        chk("t1_rsp", bus.rsp_valid, 4'b0010);
        chk("t1_quot", bus.rsp_quotient, 14);
        chk("t1_rem", bus.rsp_remainder, 2);
        chk("t1_dbz", bus.rsp_dbz, 0);
        step();
        // requester 2, divide by zero
        set_req(2, 55, 0);
        @(negedge clk); chk("t2_ready", bus.req_ready, 4'b0100);
        step(); bus.req_valid[2] = 1'b0;
        @(negedge clk);
        chk("t2_rsp", bus.rsp_valid, 4'b0100);
        chk("t2_quot", bus.rsp_quotient, 0);
        chk("t2_rem", bus.rsp_remainder, 55);
        chk("t2_dbz", bus.rsp_dbz, 1);
        chk("t2_no_start", div_start, 0);
        step();
        // stale done at issue; requester 3 withdraws while 0 is in flight
        set_req(0, 1000, 3);
        @(negedge clk); chk("t3_ready", bus.req_ready, 4'b0001);
        step(); bus.req_valid[0] = 1'b0; set_req(3, 77, 5);
        base = glog.size();
        @(negedge clk); chk("t3_stale_done", div_done, 1); chk("t3_start", div_start, 1);
        step();
        @(negedge clk); chk("t3_no_early_rsp", bus.rsp_valid, 0);
        step(); bus.req_valid[3] = 1'b0;
        drain();
        repeat (3) step();
        chk("t3_no_grant3", glog.size(), base);
        // reset while BUSY, then pointer back at 0
        set_req(2, 5000, 3);
        @(negedge clk); chk("t4_ready", bus.req_ready, 4'b0100);
        step(); bus.req_valid[2] = 1'b0;
        step(); chk("t4_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_rsp", bus.rsp_valid, 0);
        chk("t4_rst_quot", bus.rsp_quotient, 0);
        chk("t4_rst_divisor", div_divisor, 0);
        step(); rst_n = 1'b1;
        set_req(1, 9, 2); set_req(3, 8, 4);
        @(negedge clk); chk("t4_ptr0", bus.req_ready, 4'b0010);
        drain();
        // all four continuously valid from a fresh pointer
        rst_n = 1'b0; step(); rst_n = 1'b1;
        base = glog.size();
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom_range(0, 40)));
        for (int c = 0; c < 400 && glog.size() < base + 5; c++) begin
            step(); drive(0);
        end
        chk("t5_count", glog.size() >= base + 5, 1);
        if (glog.size() >= base + 5)
            for (int j = 0; j < 5; j++) chk("t5_order", glog[base + j], j % N);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step(); drive(1);
        end
        bus.req_valid = '0;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one 16-bit `int_divider` instance between `N_REQ` requesters. It accepts divide requests over per-requester valid/ready handshakes and sequences the divider's `start`/`done` protocol. It returns the quotient and remainder to the winning requester with a one-cycle response pulse. Divide-by-zero requests are answered locally without occupying the divider. The block sits between the client datapaths and the single divider.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(N_REQ)`: width of the requester index.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request pending.
- `req_dividend`  in  N_REQ×16  per-requester dividend.
- `req_divisor`  in  N_REQ×16  per-requester divisor.
- `req_ready`  out  N_REQ  one-hot; high in the cycle the request is accepted.
- `rsp_valid`  out  N_REQ  one-hot one-cycle pulse; result for that requester.
- `rsp_quotient`  out  16  shared result bus, valid with `rsp_valid`.
- `rsp_remainder`  out  16  shared result bus, valid with `rsp_valid`.
- `rsp_dbz`  out  1  divide-by-zero flag, valid with `rsp_valid`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `div_start`  out  1  to the divider's `start`.
- `div_dividend`  out  16  to the divider's `dividend`.
- `div_divisor`  out  16  to the divider's `divisor`.
- `div_quotient`  in  16  from the divider.
- `div_remainder`  in  16  from the divider.
- `div_done`  in  1  from the divider.
  - Level signal: goes high when the result is valid.
  - Stays high until the next accepted start.
  - Cleared on the edge that accepts `start`.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks grant `g`.
  - `req_ready[g]=1` combinationally in that cycle.
  - The operands and `g` are captured into registers.
  - Divisor ≠ 0: next state is ISSUE.
  - Divisor = 0: next state is RESP with the bypass result (quotient 0, remainder = dividend, `rsp_dbz=1`). The divider is not started.
- **ISSUE**
  - `div_start=1` for exactly one cycle, driven from the registered operands.
  - Next state is BUSY.
- **BUSY**
  - Wait for `div_done=1`. The check is valid from the first BUSY cycle because the divider clears `done` on the start edge.
  - On `div_done`, capture `div_quotient` and `div_remainder`, set `rsp_dbz=0`, and go to RESP.
- **RESP**
  - `rsp_valid[g]=1` for one cycle; the result registers drive the buses.
  - Next state is IDLE.
- Round-robin rules:
  - The priority pointer starts at 0 after reset.
  - After each grant the pointer becomes `(g+1) mod N_REQ`.
  - The search order is pointer, pointer+1, … wrapping.
- Divider results are passed through unmodified; no correction of divider arithmetic.
- `req_ready` is only ever asserted in IDLE. At most one bit is set.
- A requester must hold `req_valid` and its operands stable until `req_ready`.
- Deasserting `req_valid` before grant withdraws the request; no error.
- `div_dividend`/`div_divisor` hold the last issued operands between operations.

## Timing
- Reset values:
  - State IDLE, pointer 0.
  - `req_ready`, `rsp_valid`, `div_start`, `rsp_dbz`, `busy` all 0.
  - `rsp_quotient`, `rsp_remainder`, `div_dividend`, `div_divisor` all 0.
- Normal path, with accept at cycle T:
  - `div_start` at T+1.
  - BUSY from T+2.
  - `div_done` seen at cycle D.
  - `rsp_valid` at D+1.
  - Next accept is possible at D+2.
- Divide-by-zero path: accept at T, `rsp_valid` at T+1, next accept at T+2.
- `div_done` already high while in IDLE or ISSUE (stale from a previous operation) is ignored; only BUSY samples it.
- Reset asserted mid-operation:
  - Immediate return to the IDLE reset values; the in-flight request is dropped and no response is produced.
  - The divider shares `rst_n` and resets with the scheduler.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait; starvation is bounded by `N_REQ` grants.

## Structure
- Package `div_sched_pkg`:
  - `DATA_W=16`.
  - FSM state enum `sched_state_t` (IDLE, ISSUE, BUSY, RESP).
  - Shared by the bench for state probing.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, `gnt_id`, `any`.
  - Purely combinational rotate / priority / rotate-back.
  - The pointer register lives in `div_sched`.
- `div_sched` owns the FSM, operand/grant registers and result registers. The divider is instantiated alongside it at the next level up, not inside.

## Test plan
- Single request, requester 1, 100/7 → `req_ready[1]` at T, `div_start` at T+1, `rsp_valid[1]` one cycle after `div_done`; results equal the divider outputs (14, 2).
- Requester 2, 55/0 → `rsp_valid[2]` at T+1 with quotient 0, remainder 55, `rsp_dbz=1`; `div_start` never asserted.
- All four requesters valid simultaneously and continuously → grant order 0,1,2,3,0; each response bit matches its grant; no overlap of operations.
- Stale `div_done` high while the next request is issued → no premature response; the response follows the new `done` edge only.
- `rst_n` pulsed low during BUSY → all outputs at reset values immediately, no `rsp_valid`; the next request after reset is granted from pointer 0.
- Requester 3 drops `req_valid` before grant while requester 0 is busy → never granted, no response for 3.
